// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register numbers, hazard-controller states and the load-use detector.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } hazard_state_t;

    // A load in EX feeds a source of the instruction in ID; $zero never creates a dependence.
    function automatic logic load_use(input logic ex_load, input regbits_t wsel,
                                      input regbits_t rs, input regbits_t rt,
                                      input logic uses_rt);
        return ex_load && (wsel != '0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: register enables/flushes from cache handshakes,
// load-use hazards, redirects and halt, plus stall/flush performance counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_dREN,
    input  regbits_t         idex_wsel,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             redirect,
    input  logic             memwb_halt,
    output logic             pc_enable,
    output logic             pc_redirect,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_flush,
    output logic             exmem_enable,
    output logic             exmem_flush,
    output logic             memwb_enable,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state_q, state_d;
    logic          held_q, held_d;
    logic          run_rules;
    logic          eff_ihit;
    logic          flush_inc;
    logic          stall_inc;
    logic          memop;

    assign memop = exmem_dREN | exmem_dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        run_rules    = 1'b0;
        eff_ihit     = ihit;
        flush_inc    = 1'b0;
        pc_enable    = 1'b0;
        pc_redirect  = 1'b0;
        ifid_enable  = 1'b0;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b0;
        idex_flush   = 1'b0;
        exmem_enable = 1'b0;
        exmem_flush  = 1'b0;
        memwb_enable = 1'b0;
        memwb_flush  = 1'b0;
        halt         = 1'b0;

        unique case (state_q)
            RUN: begin
                if (memwb_halt) begin
                    state_d = HALTED;
                end else if (memop && !dhit) begin
                    state_d = MEMWAIT;
                    held_d  = ihit;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEMWAIT: begin
                // A fetch that completes during the freeze is remembered for the release cycle.
                if (!dhit) begin
                    held_d = held_q | ihit;
                end else begin
                    state_d   = RUN;
                    held_d    = 1'b0;
                    run_rules = 1'b1;
                    eff_ihit  = ihit | held_q;
                end
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (run_rules) begin
            if (redirect) begin
                pc_enable    = 1'b1;
                pc_redirect  = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                flush_inc    = 1'b1;
            end else if (load_use(idex_dREN, idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt) || !eff_ihit) begin
                idex_flush   = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
            end
        end
    end

    assign stall_inc = (state_q != HALTED) && !pc_enable;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clear (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clear (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; a second instance with 4-bit counters checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned PC_EN = 10, PC_RD = 9, IF_EN = 8, IF_FL = 7, ID_EN = 6,
                            ID_FL = 5, EX_EN = 4, EX_FL = 3, WB_EN = 2, WB_FL = 1, HLT = 0;

    typedef struct packed {
        logic [10:0] ctl;
        logic [15:0] stall;
        logic [15:0] flush;
        logic [3:0]  stall4;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, ifid_uses_rt, redirect, memwb_halt;
    logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
    logic        pc_enable, pc_redirect, ifid_enable, ifid_flush, idex_enable, idex_flush;
    logic        exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_enable, s_pc_redirect, s_ifid_enable, s_ifid_flush, s_idex_enable, s_idex_flush;
    logic        s_exmem_enable, s_exmem_flush, s_memwb_enable, s_memwb_flush, s_halt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    int   m_state;
    bit   m_held;
    int   m_stall, m_flush, m_stall4;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN),
        .exmem_dWEN(exmem_dWEN), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .redirect(redirect), .memwb_halt(memwb_halt), .pc_enable(pc_enable),
        .pc_redirect(pc_redirect), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
        .idex_enable(idex_enable), .idex_flush(idex_flush), .exmem_enable(exmem_enable),
        .exmem_flush(exmem_flush), .memwb_enable(memwb_enable), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN),
        .exmem_dWEN(exmem_dWEN), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .redirect(redirect), .memwb_halt(memwb_halt), .pc_enable(s_pc_enable),
        .pc_redirect(s_pc_redirect), .ifid_enable(s_ifid_enable), .ifid_flush(s_ifid_flush),
        .idex_enable(s_idex_enable), .idex_flush(s_idex_flush), .exmem_enable(s_exmem_enable),
        .exmem_flush(s_exmem_flush), .memwb_enable(s_memwb_enable), .memwb_flush(s_memwb_flush),
        .halt(s_halt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        idex_dREN = 1'b0; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ifid_uses_rt = 1'b0; redirect = 1'b0; memwb_halt = 1'b0;
    endtask

    // Predict this cycle's outputs, queue them, compare at negedge, then advance the model.
    task automatic step(input string tag);
        logic [10:0] c;
        bit   rules, eih, finc, lu;
        int   nstate;
        bit   nheld;
        exp_t e;
        c = '0; rules = 0; eih = ihit; finc = 0; nstate = m_state; nheld = m_held;
        if (m_state == 2) begin
            c[HLT] = 1'b1;
        end else if (m_state == 0) begin
            if (memwb_halt) nstate = 2;
            else if ((exmem_dREN || exmem_dWEN) && !dhit) begin nstate = 1; nheld = ihit; end
            else rules = 1;
        end else begin
            if (!dhit) nheld = m_held | ihit;
            else begin nstate = 0; nheld = 0; rules = 1; eih = ihit | m_held; end
        end
        if (rules) begin
            lu = idex_dREN && idex_wsel != 5'd0 &&
                 (idex_wsel == ifid_rs || (ifid_uses_rt && idex_wsel == ifid_rt));
            if (redirect) begin
                c[PC_EN] = 1; c[PC_RD] = 1; c[IF_FL] = 1; c[ID_FL] = 1; c[EX_EN] = 1; c[WB_EN] = 1;
                finc = 1;
            end else if (lu || !eih) begin
                c[ID_FL] = 1; c[EX_EN] = 1; c[WB_EN] = 1;
            end else begin
                c[PC_EN] = 1; c[IF_EN] = 1; c[ID_EN] = 1; c[EX_EN] = 1; c[WB_EN] = 1;
            end
        end
        sb.push_back('{ctl: c, stall: 16'(m_stall), flush: 16'(m_flush), stall4: 4'(m_stall4)});

        @(negedge CLK);
        e = sb.pop_front();
        check_eq({tag, ".ctl"}, 32'({pc_enable, pc_redirect, ifid_enable, ifid_flush, idex_enable,
                 idex_flush, exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt}), 32'(e.ctl));
        check_eq({tag, ".stall"}, 32'(stall_cnt), 32'(e.stall));
        check_eq({tag, ".flush"}, 32'(flush_cnt), 32'(e.flush));
        check_eq({tag, ".stall4"}, 32'(s_stall_cnt), 32'(e.stall4));

        @(posedge CLK);
        if (RST) begin
            m_state = 0; m_held = 0; m_stall = 0; m_flush = 0; m_stall4 = 0;
        end else begin
            if (m_state != 2 && !c[PC_EN]) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (finc && m_flush < 65535) m_flush++;
            m_state = nstate; m_held = nheld;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        m_state = 0; m_held = 0; m_stall = 0; m_flush = 0; m_stall4 = 0;
        check_eq("rst_halt", 32'(halt), 32'd0);
        check_eq("rst_stall", 32'(stall_cnt), 32'd0);
        check_eq("rst_flush", 32'(flush_cnt), 32'd0);

        for (int i = 0; i < 5; i++) step("run");
        check_eq("run_stall", 32'(stall_cnt), 32'd0);

        idex_dREN = 1; idex_wsel = 5'd5; ifid_rs = 5'd5;
        step("lu_rs");
        clear_inputs(); step("lu_after");
        check_eq("lu_stall", 32'(stall_cnt), 32'd1);
        idex_dREN = 1; idex_wsel = 5'd0; ifid_rs = 5'd0;
        step("lu_zero");
        check_eq("lu_zero_stall", 32'(stall_cnt), 32'd1);
        idex_dREN = 1; idex_wsel = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1;
        step("lu_rt");
        ifid_uses_rt = 0; step("lu_rt_unused");
        check_eq("lu_rt_stall", 32'(stall_cnt), 32'd2);

        clear_inputs(); exmem_dREN = 1; dhit = 0; ihit = 0;
        step("mw_c1");
        ihit = 1; step("mw_c2");
        ihit = 0; step("mw_c3");
        dhit = 1; step("mw_c4");
        check_eq("mw_ifid_en", 32'(ifid_enable), 32'd0);
        check_eq("mw_stall", 32'(stall_cnt), 32'd5);
        clear_inputs(); exmem_dWEN = 1; dhit = 1; step("store_hit");

        clear_inputs(); redirect = 1; ihit = 0;
        step("redir");
        check_eq("redir_cnt", 32'(flush_cnt), 32'd1);
        redirect = 1; ihit = 1; idex_dREN = 1; idex_wsel = 5'd9; ifid_rs = 5'd9;
        step("redir_lu");
        check_eq("redir_cnt2", 32'(flush_cnt), 32'd2);

        clear_inputs(); exmem_dREN = 1; ihit = 0;
        step("mwr_c1"); step("mwr_c2");
        RST = 1; step("mwr_rst");
        clear_inputs();
        check_eq("mwr_stall", 32'(stall_cnt), 32'd0);
        check_eq("mwr_flush", 32'(flush_cnt), 32'd0);
        step("mwr_run");

        ihit = 0;
        for (int i = 0; i < 20; i++) step("sat");
        check_eq("sat16", 32'(stall_cnt), 32'd20);
        check_eq("sat4", 32'(s_stall_cnt), 32'd15);

        clear_inputs(); memwb_halt = 1;
        step("halt_c0");
        check_eq("halt_set", 32'(halt), 32'd1);
        clear_inputs(); redirect = 1;
        for (int i = 0; i < 10; i++) step("halted");
        RST = 1; step("halt_rst");
        clear_inputs();
        check_eq("halt_clr", 32'(halt), 32'd0);
        step("post_halt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
